deck_manager: RTL and testbench

Owns the 106-card available-card pool and drives the `draw_once` random drawer from the requesting side. Game-control logic asks for a batch of N cards, such as a 14-card opening hand or a single draw. The block issues one draw request per card, clears each drawn card from the pool, and streams the drawn indices back. It also accepts cards returned to the pool and reports the remaining count.

---
 rtl/deck_pkg.sv | 15 +
 rtl/card_popcount.sv | 17 +
 rtl/deck_manager.sv | 133 +++++++++++++
 tb/tb_deck_manager.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deck_pkg.sv
// Shared pool sizing and batch FSM encoding for the deck manager.
// Pure declarations; no logic, no latency, no flow control.
package deck_pkg;
  localparam int CARD_NUM  = 106;
  localparam int IDX_W     = 7;
  localparam int MAX_BATCH = 14;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FINISH
  } deck_state_t;
endpackage

// File: rtl/card_popcount.sv
// Counts the set bits of the card pool mask.
// Purely combinational, zero latency; no flow control.
module card_popcount
  import deck_pkg::*;
(
  input  logic [CARD_NUM-1:0] mask,
  output logic [IDX_W-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CARD_NUM; i++) begin
      count = count + IDX_W'(mask[i]);
    end
  end

endmodule

// File: rtl/deck_manager.sv
// Card pool owner: draws batches through draw_once, streams indices, takes returns (DECK_RETURN_EN).
// Latency: card_valid one cycle after drawer_done; per card >= 2 cycles plus drawer latency.
// Backpressure: waits in REQ while drawer_ready is low; draw_req is only sampled in IDLE.
module deck_manager
  import deck_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                interboard_rst,
  input  logic                draw_req,
  input  logic [CNT_W-1:0]    draw_cnt,
  output logic                busy,
  output logic                card_valid,
  output logic [IDX_W-1:0]    card_idx,
  output logic                batch_done,
  input  logic                ret_valid,
  input  logic [IDX_W-1:0]    ret_idx,
  output logic [IDX_W-1:0]    remaining,
  output logic                empty,
  output logic                err,
  output logic [CARD_NUM-1:0] available_card,
  output logic                draw_one,
  input  logic                drawer_ready,
  input  logic                drawer_done,
  input  logic [IDX_W-1:0]    drawn_idx
);

  localparam int EXT_W = 1 << IDX_W;

  deck_state_t      state, state_nxt;
  logic [CNT_W-1:0] left;
  logic             req_ok;
  logic             clr_en;
  logic             ret_ok;
  logic             ret_err;
  logic [EXT_W-1:0] pool_ext;
  logic [EXT_W-1:0] pool_nxt;

  card_popcount u_popcount (
    .mask  (available_card),
    .count (remaining)
  );

  assign empty    = (remaining == '0);
  assign req_ok   = (draw_cnt != '0) && (draw_cnt <= CNT_W'(MAX_BATCH));
  assign clr_en   = (state == WAIT) && drawer_done && !interboard_rst;
  // Widened so any 7-bit index can be looked up without an out-of-range select.
  assign pool_ext = EXT_W'(available_card);

`ifdef DECK_RETURN_EN
  assign ret_ok  = ret_valid && !interboard_rst && (ret_idx < IDX_W'(CARD_NUM)) &&
                   !pool_ext[ret_idx] && !(clr_en && (drawn_idx == ret_idx));
  assign ret_err = ret_valid && !interboard_rst && !ret_ok;
`else
  logic unused_ret;
  assign unused_ret = ^{ret_valid, ret_idx};
  assign ret_ok     = 1'b0;
  assign ret_err    = 1'b0;
`endif

  // Clear is applied after set so a same-index collision leaves the card drawn.
  always_comb begin
    pool_nxt = pool_ext;
    if (ret_ok) begin
      pool_nxt[ret_idx] = 1'b1;
    end
    if (clr_en) begin
      pool_nxt[drawn_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (interboard_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (draw_req && req_ok) state_nxt = REQ;
      REQ:     if (empty) state_nxt = FINISH;
               else if (drawer_ready) state_nxt = WAIT;
      WAIT:    if (drawer_done) state_nxt = (left == CNT_W'(1)) ? FINISH : REQ;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    draw_one   = 1'b0;
    batch_done = 1'b0;
    err        = ret_err;
    if (!interboard_rst) begin
      case (state)
        IDLE:    if (draw_req && !req_ok) err = 1'b1;
        REQ:     if (empty) err = 1'b1;
                 else draw_one = drawer_ready;
        FINISH:  batch_done = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      available_card <= '1;
      left           <= '0;
      card_valid     <= 1'b0;
      card_idx       <= '0;
    end else if (interboard_rst) begin
      available_card <= '1;
      left           <= '0;
      card_valid     <= 1'b0;
      card_idx       <= '0;
    end else begin
      available_card <= pool_nxt[CARD_NUM-1:0];
      card_valid     <= clr_en;
      if (clr_en) begin
        card_idx <= drawn_idx;
        left     <= left - CNT_W'(1);
      end else if ((state == IDLE) && draw_req && req_ok) begin
        left <= draw_cnt;
      end
    end
  end

endmodule

// File: tb/tb_deck_manager.sv
// Bench for deck_manager: table vectors for IDLE requests/returns, directed batch corner cases,
// and randomized batches against a pool model driven by a behavioural draw_once stand-in.
module tb_deck_manager;
  import deck_pkg::*;

`ifdef DECK_RETURN_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                interboard_rst;
  logic                draw_req;
  logic [CNT_W-1:0]    draw_cnt;
  logic                busy;
  logic                card_valid;
  logic [IDX_W-1:0]    card_idx;
  logic                batch_done;
  logic                ret_valid;
  logic [IDX_W-1:0]    ret_idx;
  logic [IDX_W-1:0]    remaining;
  logic                empty;
  logic                err;
  logic [CARD_NUM-1:0] available_card;
  logic                draw_one;
  logic                drawer_ready;
  logic                drawer_done;
  logic [IDX_W-1:0]    drawn_idx;

  int n_checks = 0;
  int n_pass   = 0;
  bit pool[CARD_NUM];
  int forced_q[$];

  typedef struct {
    bit         req;
    logic [3:0] cnt;
    bit         rv;
    int         ridx;
    bit         exp_err;
    int         exp_delta;
  } vec_t;
  vec_t tbl[7];

  deck_manager dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .draw_req       (draw_req),
    .draw_cnt       (draw_cnt),
    .busy           (busy),
    .card_valid     (card_valid),
    .card_idx       (card_idx),
    .batch_done     (batch_done),
    .ret_valid      (ret_valid),
    .ret_idx        (ret_idx),
    .remaining      (remaining),
    .empty          (empty),
    .err            (err),
    .available_card (available_card),
    .draw_one       (draw_one),
    .drawer_ready   (drawer_ready),
    .drawer_done    (drawer_done),
    .drawn_idx      (drawn_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int pool_count();
    int c = 0;
    for (int i = 0; i < CARD_NUM; i++) c += int'(pool[i]);
    return c;
  endfunction

  function automatic logic [CARD_NUM-1:0] model_mask();
    logic [CARD_NUM-1:0] m;
    for (int i = 0; i < CARD_NUM; i++) m[i] = pool[i];
    return m;
  endfunction

  // Uniform choice among the cards the model still holds.
  function automatic int pick_random();
    int c = pool_count();
    int r;
    if (c == 0) return 0;
    r = $urandom_range(0, c - 1);
    for (int i = 0; i < CARD_NUM; i++) begin
      if (pool[i]) begin
        if (r == 0) return i;
        r--;
      end
    end
    return 0;
  endfunction

  task automatic idle_inputs();
    interboard_rst = 1'b0;
    draw_req       = 1'b0;
    ret_valid      = 1'b0;
    drawer_done    = 1'b0;
    drawer_ready   = 1'b1;
  endtask

  // One batch of n cards; ret_at injects a return on the first drawer_done,
  // abort_after raises interboard_rst in WAIT once that many cards have streamed out.
  task automatic run_batch(input int n, input bit rnd_ready, input int ret_at, input int abort_after);
    int c0        = pool_count();
    int exp_cards = (n < c0) ? n : c0;
    int exp_errs  = (n > c0) ? 1 : 0;
    int cards = 0, errs = 0, lat = 0, cyc = 0, pend = 0;
    bit outstanding = 0, finished = 0, aborted = 0, ret_chk = 0, ret_err_exp = 0, legal;
    int exp_q[$];
    draw_req = 1'b1;
    draw_cnt = n[3:0];
    #1;
    chk("req_cycle_err", err, 0);
    chk("req_cycle_busy", busy, 0);
    @(posedge clk); #1;
    draw_req = 1'b0;
    while (!finished && cyc < 400) begin
      cyc++;
      drawer_done    = 1'b0;
      ret_valid      = 1'b0;
      interboard_rst = 1'b0;
      drawer_ready   = outstanding ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (outstanding && abort_after >= 0 && cards == abort_after) begin
        interboard_rst = 1'b1;
        aborted        = 1'b1;
        outstanding    = 1'b0;
      end else if (outstanding && lat == 0) begin
        drawer_done = 1'b1;
        drawn_idx   = pend[IDX_W-1:0];
        exp_q.push_back(pend);
        if (ret_at >= 0) begin
          ret_valid   = 1'b1;
          ret_idx     = ret_at[IDX_W-1:0];
          legal       = RET_EN && (ret_at < CARD_NUM) && !pool[ret_at] && (ret_at != pend);
          if (legal) pool[ret_at] = 1'b1;
          ret_chk     = 1'b1;
          ret_err_exp = RET_EN && !legal;
          ret_at      = -1;
        end
        pool[pend]  = 1'b0;
        outstanding = 1'b0;
      end else if (outstanding) begin
        lat--;
      end
      #1;
      if (cyc == 1 && !rnd_ready) chk("draw_one_first_req_cycle", draw_one, c0 > 0);
      if (ret_chk) begin
        chk("same_cycle_return_err", err, ret_err_exp);
        ret_chk = 1'b0;
      end else if (err) begin
        errs++;
      end
      if (draw_one) begin
        chk("draw_one_protocol", outstanding || !drawer_ready, 0);
        pend        = (forced_q.size() > 0) ? forced_q.pop_front() : pick_random();
        outstanding = 1'b1;
        lat         = $urandom_range(0, 2);
      end
      if (card_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_card_valid", card_valid, 0);
        end else begin
          chk("card_idx", card_idx, exp_q.pop_front());
          cards++;
          chk("remaining_on_card", remaining, pool_count());
          chk("mask_on_card", available_card == model_mask(), 1);
        end
      end
      if (batch_done) begin
        chk("busy_in_finish", busy, 1);
        finished = 1'b1;
      end
      @(posedge clk); #1;
      if (aborted) break;
    end
    idle_inputs();
    #1;
    if (aborted) begin
      for (int i = 0; i < CARD_NUM; i++) pool[i] = 1'b1;
      chk("abort_idle_next_cycle", busy, 0);
      chk("abort_mask_all_ones", available_card == model_mask(), 1);
      chk("abort_remaining", remaining, CARD_NUM);
      for (int k = 0; k < 5; k++) begin
        chk("abort_no_batch_done", batch_done, 0);
        @(posedge clk); #1;
      end
    end else begin
      chk("batch_finished_in_budget", finished, 1);
      chk("batch_card_count", cards, exp_cards);
      chk("batch_err_count", errs, exp_errs);
      chk("idle_after_batch", busy, 0);
      chk("remaining_after_batch", remaining, pool_count());
      chk("empty_after_batch", empty, pool_count() == 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, n;
    tbl[0] = '{1'b1, 4'd0,  1'b0, 0,   1'b1,   0};
    tbl[1] = '{1'b1, 4'd15, 1'b0, 0,   1'b1,   0};
    tbl[2] = '{1'b0, 4'd0,  1'b1, 4,   1'b0,   RET_EN ? 1 : 0};
    tbl[3] = '{1'b0, 4'd0,  1'b1, 4,   RET_EN, 0};
    tbl[4] = '{1'b0, 4'd0,  1'b1, 110, RET_EN, 0};
    tbl[5] = '{1'b0, 4'd0,  1'b1, 50,  RET_EN, 0};
    tbl[6] = '{1'b1, 4'd15, 1'b1, 10,  1'b1,   RET_EN ? 1 : 0};

    for (int i = 0; i < CARD_NUM; i++) pool[i] = 1'b1;
    rst       = 1'b0;
    idle_inputs();
    draw_cnt  = '0;
    ret_idx   = '0;
    drawn_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("reset_mask", available_card == model_mask(), 1);
    chk("reset_remaining", remaining, 106);
    chk("reset_empty", empty, 0);
    chk("reset_busy", busy, 0);
    chk("reset_card_valid", card_valid, 0);
    chk("reset_card_idx", card_idx, 0);
    chk("reset_batch_done", batch_done, 0);
    chk("reset_err", err, 0);
    chk("reset_draw_one", draw_one, 0);
    @(posedge clk); #1;

    // Opening hand with known indices 1,4,...,40.
    for (int k = 0; k < 14; k++) forced_q.push_back(3 * k + 1);
    run_batch(14, 1'b0, -1, -1);
    chk("opening_hand_remaining", remaining, 92);

    for (int i = 0; i < 7; i++) begin
      r0        = pool_count();
      draw_req  = tbl[i].req;
      draw_cnt  = tbl[i].cnt;
      ret_valid = tbl[i].rv;
      ret_idx   = tbl[i].ridx[IDX_W-1:0];
      #1;
      chk($sformatf("vec%0d_err", i), err, tbl[i].exp_err);
      @(posedge clk); #1;
      idle_inputs();
      if (tbl[i].exp_delta != 0) pool[tbl[i].ridx] = 1'b1;
      chk($sformatf("vec%0d_busy", i), busy, 0);
      chk($sformatf("vec%0d_remaining", i), remaining, r0 + tbl[i].exp_delta);
      chk($sformatf("vec%0d_mask", i), available_card == model_mask(), 1);
    end

    r0 = pool_count();
    forced_q.push_back(8);
    run_batch(1, 1'b0, 7, -1);
    chk("same_cycle_bit7", available_card[7], RET_EN);
    chk("same_cycle_bit8", available_card[8], 0);
    chk("same_cycle_remaining", remaining, RET_EN ? r0 : r0 - 1);

    forced_q.push_back(9);
    run_batch(1, 1'b0, 9, -1);
    chk("collision_bit9_cleared", available_card[9], 0);

    run_batch(14, 1'b1, -1, 3);

    while (pool_count() > 2) begin
      n = $urandom_range(1, 14);
      if (n > pool_count() - 2) n = pool_count() - 2;
      run_batch(n, 1'b1, -1, -1);
    end

    run_batch(5, 1'b1, -1, -1);
    chk("drained_empty", empty, 1);
    chk("drained_remaining", remaining, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
